// File: rtl/sram_arbiter.sv
// Two-port arbiter and cycle sequencer for the external 512K x 16 async SRAM.
// Port A (stream DMA) has priority; port B is forced in after MAX_A_RUN A grants.
module sram_arbiter #(
   parameter int STROBE_CYC = 2,
   parameter int MAX_A_RUN  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [1:0]  a_be,
   input  logic [18:0] a_adr,
   input  logic [15:0] a_wdata,
   output logic        a_ack,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [1:0]  b_be,
   input  logic [18:0] b_adr,
   input  logic [15:0] b_wdata,
   output logic        b_ack,
   output logic [15:0] rdata,
   output logic        busy,
   output logic        owner,
   output logic [18:0] sram_adr,
   output logic [15:0] sram_dout,
   input  logic [15:0] sram_din,
   output logic        sram_t,
   output logic        cs_n,
   output logic        we_n,
   output logic        oe_n,
   output logic        ub_n,
   output logic        lb_n
);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   state_t      state, state_nx;
   logic [3:0]  stb_cnt;
   logic [7:0]  run_cnt;
   logic        acc_we;
   logic [1:0]  acc_be;
   logic        grant, pick_b;
   logic        nx_we;
   logic [1:0]  nx_be;

   always_comb begin
      pick_b   = b_req && (!a_req || run_cnt == 8'(MAX_A_RUN));
      grant    = a_req || b_req;
      state_nx = state;
      case (state)
         IDLE:    if (grant) state_nx = SETUP;
         SETUP:   state_nx = STROBE;
         STROBE:  if (stb_cnt == 4'(STROBE_CYC - 1)) state_nx = HOLD;
         HOLD:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      // the winner's attributes must reach the pins on the same edge it is latched
      nx_we = acc_we;
      nx_be = acc_be;
      if (state == IDLE) begin
         nx_we = pick_b ? b_we : a_we;
         nx_be = pick_b ? b_be : a_be;
      end
   end

   // Pin controls are registered from the next state so the SRAM sees glitch-free strobes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         stb_cnt   <= '0;
         run_cnt   <= '0;
         acc_we    <= 1'b0;
         acc_be    <= 2'b00;
         owner     <= 1'b0;
         busy      <= 1'b0;
         a_ack     <= 1'b0;
         b_ack     <= 1'b0;
         rdata     <= '0;
         sram_adr  <= '0;
         sram_dout <= '0;
         sram_t    <= 1'b1;
         cs_n      <= 1'b1;
         we_n      <= 1'b1;
         oe_n      <= 1'b1;
         ub_n      <= 1'b1;
         lb_n      <= 1'b1;
      end else begin
         state   <= state_nx;
         stb_cnt <= (state == STROBE) ? 4'(stb_cnt + 4'd1) : 4'd0;
         if (state == IDLE && grant) begin
            owner    <= pick_b;
            acc_we   <= nx_we;
            acc_be   <= nx_be;
            sram_adr <= pick_b ? b_adr : a_adr;
            if (nx_we) sram_dout <= pick_b ? b_wdata : a_wdata;
            if (pick_b || !b_req)              run_cnt <= '0;
            else if (run_cnt != 8'(MAX_A_RUN)) run_cnt <= 8'(run_cnt + 8'd1);
         end
         if (state == STROBE && state_nx == HOLD && !acc_we) rdata <= sram_din;
         busy   <= (state_nx != IDLE);
         cs_n   <= (state_nx == IDLE);
         we_n   <= !(state_nx == STROBE && nx_we);
         oe_n   <= !(state_nx == STROBE && !nx_we);
         sram_t <= !(state_nx != IDLE && nx_we);
         ub_n   <= (state_nx == IDLE) || !nx_be[1];
         lb_n   <= (state_nx == IDLE) || !nx_be[0];
         a_ack  <= (state_nx == HOLD) && !owner;
         b_ack  <= (state_nx == HOLD) && owner;
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: default build with an SRAM model, plus a STROBE_CYC=4 build.
module tb_sram_arbiter;

   logic clk = 1'b0;
   always #20 clk = ~clk;

   logic        rst;
   logic        a_req, a_we, b_req, b_we;
   logic [1:0]  a_be, b_be;
   logic [18:0] a_adr, b_adr;
   logic [15:0] a_wdata, b_wdata;
   logic        a_ack, b_ack, busy, owner, sram_t, cs_n, we_n, oe_n, ub_n, lb_n;
   logic [15:0] rdata, sram_dout, sram_din;
   logic [18:0] sram_adr;

   logic        a_req4;
   logic        a_ack4, b_ack4, busy4, owner4, sram_t4, cs_n4, we_n4, oe_n4, ub_n4, lb_n4;
   logic [15:0] rdata4, sram_dout4;
   logic [15:0] din4 = 16'h0000;
   logic [18:0] sram_adr4;
   int          k4 = 0;

   int vectors = 0;
   int errors  = 0;

   sram_arbiter dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_adr(a_adr), .a_wdata(a_wdata), .a_ack(a_ack),
      .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_adr(b_adr), .b_wdata(b_wdata), .b_ack(b_ack),
      .rdata(rdata), .busy(busy), .owner(owner), .sram_adr(sram_adr), .sram_dout(sram_dout),
      .sram_din(sram_din), .sram_t(sram_t), .cs_n(cs_n), .we_n(we_n), .oe_n(oe_n),
      .ub_n(ub_n), .lb_n(lb_n));

   sram_arbiter #(.STROBE_CYC(4), .MAX_A_RUN(8)) u4 (
      .clk(clk), .rst(rst),
      .a_req(a_req4), .a_we(1'b0), .a_be(2'b11), .a_adr(19'h0ABCD), .a_wdata(16'h0000), .a_ack(a_ack4),
      .b_req(1'b0), .b_we(1'b0), .b_be(2'b00), .b_adr(19'h00000), .b_wdata(16'h0000), .b_ack(b_ack4),
      .rdata(rdata4), .busy(busy4), .owner(owner4), .sram_adr(sram_adr4), .sram_dout(sram_dout4),
      .sram_din(din4), .sram_t(sram_t4), .cs_n(cs_n4), .we_n(we_n4), .oe_n(oe_n4),
      .ub_n(ub_n4), .lb_n(lb_n4));

   // simple SRAM model with byte lanes
   logic [15:0] mem [0:524287];
   assign sram_din = mem[sram_adr];
   always @(posedge clk) begin
      if (!cs_n && !we_n) begin
         if (!ub_n) mem[sram_adr][15:8] <= sram_dout[15:8];
         if (!lb_n) mem[sram_adr][7:0]  <= sram_dout[7:0];
      end
   end

   // distinct data on each strobe clock of the STROBE_CYC=4 build
   always @(negedge clk) begin
      if (!oe_n4) begin
         k4   = k4 + 1;
         din4 = 16'hB000 | 16'(k4);
      end else k4 = 0;
   end

   task automatic access(input bit port, input bit we, input logic [1:0] be, input logic [18:0] adr,
                         input logic [15:0] wd, output int lat, output int cs_lo, output int we_lo,
                         output int oe_lo, output int t_lo, output int ub_lo, output int lb_lo,
                         output int adr_bad);
      lat = -1; cs_lo = 0; we_lo = 0; oe_lo = 0; t_lo = 0; ub_lo = 0; lb_lo = 0; adr_bad = 0;
      if (port) begin b_we = we; b_be = be; b_adr = adr; b_wdata = wd; b_req = 1'b1; end
      else      begin a_we = we; a_be = be; a_adr = adr; a_wdata = wd; a_req = 1'b1; end
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (!cs_n) begin
            cs_lo++;
            if (!ub_n) ub_lo++;
            if (!lb_n) lb_lo++;
            if (sram_adr !== adr) adr_bad++;
         end
         if (!we_n)   we_lo++;
         if (!oe_n)   oe_lo++;
         if (!sram_t) t_lo++;
         if (port ? b_ack : a_ack) begin lat = i; break; end
      end
      a_req = 1'b0; b_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      a_req = 1'b1; a_we = 1'b1; a_be = 2'b11; a_adr = 19'h1; a_wdata = 16'hFFFF;
      b_req = 1'b1; b_we = 1'b0; b_be = 2'b11; b_adr = 19'h2; b_wdata = 16'hFFFF;
      a_req4 = 1'b0;
      repeat (3) @(negedge clk);
      vectors++; if ({cs_n, we_n, oe_n, ub_n, lb_n, sram_t} !== 6'b111111) begin errors++;
         $display("FAIL rst_ctrl: got %b want 111111", {cs_n, we_n, oe_n, ub_n, lb_n, sram_t}); end
      vectors++; if ({a_ack, b_ack, busy, owner} !== 4'b0000) begin errors++;
         $display("FAIL rst_status: got %b want 0000", {a_ack, b_ack, busy, owner}); end
      vectors++; if (rdata !== 16'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0000", rdata); end
      vectors++; if (sram_adr !== 19'h0) begin errors++; $display("FAIL rst_adr: got %h want 00000", sram_adr); end
      vectors++; if (sram_dout !== 16'h0) begin errors++; $display("FAIL rst_dout: got %h want 0000", sram_dout); end
      a_req = 1'b0; b_req = 1'b0;
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write_read();
      int lat, cs_lo, we_lo, oe_lo, t_lo, ub_lo, lb_lo, adr_bad;
      access(1'b1, 1'b1, 2'b11, 19'h12345, 16'hA5C3, lat, cs_lo, we_lo, oe_lo, t_lo, ub_lo, lb_lo, adr_bad);
      vectors++; if (lat !== 4) begin errors++; $display("FAIL wr_lat: got %0d want 4", lat); end
      vectors++; if (we_lo !== 2) begin errors++; $display("FAIL wr_we_low: got %0d want 2", we_lo); end
      vectors++; if (cs_lo !== 4) begin errors++; $display("FAIL wr_cs_low: got %0d want 4", cs_lo); end
      vectors++; if (t_lo !== 4) begin errors++; $display("FAIL wr_t_low: got %0d want 4", t_lo); end
      vectors++; if (oe_lo !== 0) begin errors++; $display("FAIL wr_oe_low: got %0d want 0", oe_lo); end
      vectors++; if (adr_bad !== 0) begin errors++; $display("FAIL wr_adr: got %0d bad want 0", adr_bad); end
      access(1'b1, 1'b0, 2'b11, 19'h12345, 16'h0000, lat, cs_lo, we_lo, oe_lo, t_lo, ub_lo, lb_lo, adr_bad);
      vectors++; if (lat !== 4) begin errors++; $display("FAIL rd_lat: got %0d want 4", lat); end
      vectors++; if (rdata !== 16'hA5C3) begin errors++; $display("FAIL rd_data: got %h want a5c3", rdata); end
      vectors++; if (oe_lo !== 2) begin errors++; $display("FAIL rd_oe_low: got %0d want 2", oe_lo); end
      vectors++; if (t_lo !== 0 || we_lo !== 0) begin errors++;
         $display("FAIL rd_drive: got t_low=%0d we_low=%0d want 0 0", t_lo, we_lo); end
      vectors++; if (owner !== 1'b1) begin errors++; $display("FAIL rd_owner: got %b want 1", owner); end
   endtask

   task automatic test_priority();
      bit seq [18];
      int gap [18];
      int n = 0, last = 0, both = 0;
      for (int i = 0; i < 18; i++) begin seq[i] = 1'b0; gap[i] = 0; end
      a_we = 1'b0; a_be = 2'b11; a_adr = 19'h00010;
      b_we = 1'b0; b_be = 2'b11; b_adr = 19'h00020;
      a_req = 1'b1; b_req = 1'b1;
      for (int c = 1; c <= 120 && n < 18; c++) begin
         @(negedge clk);
         if (a_ack && b_ack) both++;
         if (a_ack || b_ack) begin seq[n] = b_ack; gap[n] = c - last; last = c; n++; end
      end
      a_req = 1'b0; b_req = 1'b0;
      @(negedge clk);
      vectors++; if (n !== 18) begin errors++; $display("FAIL prio_count: got %0d acks want 18", n); end
      vectors++; if (both !== 0) begin errors++; $display("FAIL prio_both: got %0d want 0", both); end
      for (int i = 0; i < 18; i++) begin
         vectors++; if (seq[i] !== (i % 9 == 8)) begin errors++;
            $display("FAIL prio_order[%0d]: got port %0d want %0d", i, seq[i], (i % 9 == 8)); end
         vectors++; if (gap[i] !== ((i == 0) ? 4 : 5)) begin errors++;
            $display("FAIL prio_gap[%0d]: got %0d want %0d", i, gap[i], (i == 0) ? 4 : 5); end
      end
   endtask

   task automatic test_byte_lanes();
      int lat, cs_lo, we_lo, oe_lo, t_lo, ub_lo, lb_lo, adr_bad;
      access(1'b1, 1'b1, 2'b10, 19'h00100, 16'h1234, lat, cs_lo, we_lo, oe_lo, t_lo, ub_lo, lb_lo, adr_bad);
      vectors++; if (ub_lo !== 4 || lb_lo !== 0) begin errors++;
         $display("FAIL be10_lanes: got ub_low=%0d lb_low=%0d want 4 0", ub_lo, lb_lo); end
      access(1'b0, 1'b1, 2'b00, 19'h00101, 16'h5678, lat, cs_lo, we_lo, oe_lo, t_lo, ub_lo, lb_lo, adr_bad);
      vectors++; if (ub_lo !== 0 || lb_lo !== 0) begin errors++;
         $display("FAIL be00_lanes: got ub_low=%0d lb_low=%0d want 0 0", ub_lo, lb_lo); end
      vectors++; if (lat !== 4) begin errors++; $display("FAIL be00_ack: got lat %0d want 4", lat); end
   endtask

   task automatic test_reset_mid();
      bit ack_seen = 1'b0;
      int lat = -1;
      a_we = 1'b1; a_be = 2'b11; a_adr = 19'h00042; a_wdata = 16'hBEEF; a_req = 1'b1;
      repeat (3) begin @(negedge clk); if (a_ack) ack_seen = 1'b1; end
      vectors++; if (we_n !== 1'b0) begin errors++; $display("FAIL mid_in_strobe: got we_n %b want 0", we_n); end
      rst = 1'b0;
      #1;
      vectors++; if ({cs_n, we_n, sram_t, busy, a_ack} !== 5'b11100) begin errors++;
         $display("FAIL mid_abort: got %b want 11100", {cs_n, we_n, sram_t, busy, a_ack}); end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (a_ack) begin lat = i; break; end
      end
      a_req = 1'b0;
      @(negedge clk);
      vectors++; if (ack_seen) begin errors++; $display("FAIL mid_no_ack: got ack before reset want none"); end
      vectors++; if (lat !== 4) begin errors++; $display("FAIL mid_retry_lat: got %0d want 4", lat); end
      vectors++; if (mem[19'h00042] !== 16'hBEEF) begin errors++;
         $display("FAIL mid_retry_data: got %h want beef", mem[19'h00042]); end
   endtask

   task automatic test_strobe4();
      int lat = -1, oe_lo = 0;
      a_req4 = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (!oe_n4) oe_lo++;
         if (a_ack4) begin lat = i; break; end
      end
      a_req4 = 1'b0;
      @(negedge clk);
      vectors++; if (oe_lo !== 4) begin errors++; $display("FAIL s4_oe_low: got %0d want 4", oe_lo); end
      vectors++; if (lat !== 6) begin errors++; $display("FAIL s4_lat: got %0d want 6", lat); end
      vectors++; if (rdata4 !== 16'hB004) begin errors++; $display("FAIL s4_rdata: got %h want b004", rdata4); end
   endtask

   task automatic test_boundary();
      int lat, cs_lo, we_lo, oe_lo, t_lo, ub_lo, lb_lo, adr_bad;
      access(1'b1, 1'b1, 2'b11, 19'h7FFFF, 16'h5A5A, lat, cs_lo, we_lo, oe_lo, t_lo, ub_lo, lb_lo, adr_bad);
      access(1'b1, 1'b0, 2'b11, 19'h7FFFF, 16'h0000, lat, cs_lo, we_lo, oe_lo, t_lo, ub_lo, lb_lo, adr_bad);
      vectors++; if (adr_bad !== 0 || cs_lo !== 4) begin errors++;
         $display("FAIL top_adr: got bad=%0d cs_low=%0d want 0 4", adr_bad, cs_lo); end
      vectors++; if (rdata !== 16'h5A5A) begin errors++; $display("FAIL top_rdata: got %h want 5a5a", rdata); end
      access(1'b0, 1'b1, 2'b11, 19'h00000, 16'hFFFF, lat, cs_lo, we_lo, oe_lo, t_lo, ub_lo, lb_lo, adr_bad);
      vectors++; if (adr_bad !== 0 || cs_lo !== 4) begin errors++;
         $display("FAIL zero_adr: got bad=%0d cs_low=%0d want 0 4", adr_bad, cs_lo); end
      vectors++; if (rdata !== 16'h5A5A) begin errors++; $display("FAIL wr_keeps_rdata: got %h want 5a5a", rdata); end
      vectors++; if (mem[19'h00000] !== 16'hFFFF) begin errors++;
         $display("FAIL zero_data: got %h want ffff", mem[19'h00000]); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_priority();
      test_byte_lanes();
      test_reset_mid();
      test_strobe4();
      test_boundary();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Arbitrates the single external 512K x 16 async SRAM between two requesters.
  - Port A: the real-time stream DMA, which is the priority port.
  - Port B: the UART command/compare master, which is the background port.
- Sequences each SRAM read or write cycle with programmable strobe width.
- Sits between those requesters and the SRAM pins and IOBUF bank, on the 25 MHz domain.

Parameters:
- STROBE_CYC, 2, clocks that we_n/oe_n are held low (1..15).
- MAX_A_RUN, 8, max consecutive port-A grants while port B is pending before B is forced in (1..255).

Ports:
- clk  in  1  system clock (25 MHz domain)
- rst  in  1  asynchronous, active-low reset
- a_req  in  1  port A access request (level)
- a_we  in  1  port A: 1=write, 0=read
- a_be  in  2  port A byte enables, active high, [1]=upper, [0]=lower
- a_adr  in  19  port A word address
- a_wdata  in  16  port A write data
- a_ack  out  1  port A one-cycle completion pulse
- b_req, b_we, b_be, b_adr, b_wdata, b_ack  same as port A, for port B
- rdata  out  16  read data of the last completed read, valid from its ack onward
- busy  out  1  access in progress (state != IDLE)
- owner  out  1  owner of the current or last access, 0=A, 1=B
- sram_adr  out  19  SRAM address
- sram_dout  out  16  data to the IOBUF I inputs
- sram_din  in  16  data from the IOBUF O outputs
- sram_t  out  1  IOBUF tri-state: 1=input, 0=drive
- cs_n, we_n, oe_n, ub_n, lb_n  out  1 each  SRAM controls, active low

Behaviour:
- Reset (rst=0, async) forces all outputs to these values:
  - cs_n=we_n=oe_n=ub_n=lb_n=1, sram_t=1.
  - a_ack=b_ack=0, busy=0, owner=0.
  - rdata=0, sram_adr=0, sram_dout=0.
  - State IDLE, run counter 0.
- Reset mid-access aborts the access with no ack. A requester still holding req is served after release.
- Handshake:
  - req is a level. adr/we/be/wdata must stay stable from req rise until the ack cycle.
  - req may stay high after ack to request the next access.
  - req dropped before ack is a protocol error; behaviour is undefined and need not be handled.
- States: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
- IDLE:
  - Winner selection:
    - If only one req is high, that port wins.
    - If both are high, A wins unless the run counter equals MAX_A_RUN, in which case B wins.
  - On a win: latch adr/we/be/wdata and owner, set busy=1, go to SETUP.
  - Run counter update:
    - Increments on each A grant made while b_req=1, saturating at MAX_A_RUN.
    - Clears on any B grant, or on any A grant made while b_req=0.
- SETUP (1 clk):
  - cs_n=0, sram_adr driven, ub_n/lb_n = ~be.
  - Write: sram_t=0, sram_dout=wdata.
- STROBE (STROBE_CYC clks):
  - Write: we_n=0. Read: oe_n=0.
  - On the clock edge ending the last STROBE cycle of a read, rdata <= sram_din.
- HOLD (1 clk):
  - we_n=oe_n=1. cs_n, adr and data are still held, so address/data hold time is met.
  - The owner's ack=1 for exactly this cycle.
  - Next clk: cs_n=1, sram_t=1, busy=0, go to IDLE.
- Timing:
  - Latency: req seen in IDLE at edge 0 -> ack high during cycle 2+STROBE_CYC, i.e. cycle 4 with the default.
  - Back-to-back throughput is one access per 3+STROBE_CYC clocks (5 with the default). IDLE always takes one clock.
- Signal rules:
  - we_n and oe_n are never low together.
  - sram_t=0 only inside write SETUP/STROBE/HOLD.
  - cs_n is low for exactly 2+STROBE_CYC clocks per access.
  - Write cycles leave rdata unchanged.
- Byte enables: be=2'b00 is still executed as a full cycle with ub_n=lb_n=1 (no-op) and is acked.
- Address 19'h7FFFF is a legal address; there is no wrap logic, the address passes through unchanged.

Test Plan:
- Single write then read: B write adr=0x12345 data=0xA5C3 be=11, then B read of the same adr with the model returning 0xA5C3.
  - Each ack arrives 4 clks after req.
  - rdata=0xA5C3.
  - we_n low 2 clks; sram_t=0 only during the write.
- Priority and starvation guard: a_req and b_req both held high continuously.
  - Grant order is A x8, B, A x8, B...
  - Exactly one ack per 5 clks, never both acks in the same cycle.
- Byte lanes:
  - be=2'b10 write -> ub_n=0, lb_n=1 during cs_n low.
  - be=2'b00 -> both lanes high and the ack is still issued.
- Reset mid-STROBE: assert rst in the 2nd STROBE cycle of an A write.
  - Controls go idle asynchronously, with no a_ack.
  - After release, with a_req still high, the write repeats and a_ack arrives 4 clks later.
- STROBE_CYC=4 build: read access.
  - oe_n low 4 clks, ack at cycle 6.
  - rdata captured from the sram_din value present at the end of the 4th strobe clk.
- Boundary: adr=0x7FFFF read followed by adr=0x00000 write.
  - sram_adr exact on both accesses.
  - rdata unchanged by the write.
